// File: rtl/aes128_decrypt32.sv
// Iterative AES-128 inverse cipher working on one 32-bit state column per cycle.
// The cipher key is expanded forward to K10, then the schedule is unrolled backwards round by round.
module aes128_decrypt32 (
  input  logic         clock,
  input  logic         reset,
  input  logic         ce,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [127:0] data_out,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, KEXP, ARK0, ROUND, DONE} phase_t;

  phase_t       phase_q;
  logic [3:0]   cnt_q;
  logic [1:0]   col_q;
  logic [127:0] state_q, shadow_q, key_q, data_out_q;
  logic         done_q;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  // Field inverse as a^254; maps 0 to 0, which is what the S-box needs.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    case (c)
      2'd0:    return s[127:96];
      2'd1:    return s[95:64];
      2'd2:    return s[63:32];
      default: return s[31:0];
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [1:0] c,
                                          input logic [1:0] r);
    logic [31:0] w;
    w = get_col(s, c);
    case (r)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  logic [31:0]  kw0, kw1, kw2, kw3, w4, w5, w6, w7;
  logic [31:0]  sb_in, sb_out, g_word, t_col, new_col;
  logic [3:0]   rcon_idx;
  logic [127:0] key_fwd_d, key_inv_d, shadow_d;

  always_comb begin
    {kw0, kw1, kw2, kw3} = key_q;
    // The forward S-boxes serve expansion (old w3) and unrolling (recovered w3).
    sb_in  = (phase_q == KEXP) ? kw3 : (kw3 ^ kw2);
    sb_out = {sbox(sb_in[31:24]), sbox(sb_in[23:16]), sbox(sb_in[15:8]), sbox(sb_in[7:0])};
    if (phase_q == KEXP)      rcon_idx = cnt_q + 4'd1;
    else if (phase_q == ARK0) rcon_idx = 4'd10;
    else                      rcon_idx = 4'd10 - cnt_q;
    g_word    = {sb_out[23:0], sb_out[31:24]} ^ {rcon(rcon_idx), 24'h000000};
    w4        = kw0 ^ g_word;
    w5        = w4 ^ kw1;
    w6        = w5 ^ kw2;
    w7        = w6 ^ kw3;
    key_fwd_d = {w4, w5, w6, w7};
    key_inv_d = {kw0 ^ g_word, kw1 ^ kw0, kw2 ^ kw1, kw3 ^ kw2};

    // Row r of output column c comes from state column (c - r) mod 4.
    t_col = {inv_sbox(get_byte(state_q, col_q,         2'd0)),
             inv_sbox(get_byte(state_q, col_q - 2'd1,  2'd1)),
             inv_sbox(get_byte(state_q, col_q - 2'd2,  2'd2)),
             inv_sbox(get_byte(state_q, col_q - 2'd3,  2'd3))} ^ get_col(key_q, col_q);
    if (phase_q == ARK0)     new_col = get_col(state_q, col_q) ^ get_col(key_q, col_q);
    else if (cnt_q == 4'd10) new_col = t_col;
    else                     new_col = inv_mix(t_col);

    shadow_d = shadow_q;
    case (col_q)
      2'd0:    shadow_d[127:96] = new_col;
      2'd1:    shadow_d[95:64]  = new_col;
      2'd2:    shadow_d[63:32]  = new_col;
      default: shadow_d[31:0]   = new_col;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q    <= IDLE;
      cnt_q      <= 4'd0;
      col_q      <= 2'd0;
      state_q    <= '0;
      shadow_q   <= '0;
      key_q      <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else if (done_q) begin
      if (!ce) begin
        done_q  <= 1'b0;
        phase_q <= IDLE;
      end
    end else if (ce) begin
      case (phase_q)
        IDLE: begin
          state_q <= data_in;
          key_q   <= key;
          cnt_q   <= 4'd0;
          col_q   <= 2'd0;
          phase_q <= KEXP;
        end
        KEXP: begin
          key_q <= key_fwd_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            cnt_q   <= 4'd0;
            phase_q <= ARK0;
          end
        end
        ARK0: begin
          shadow_q <= shadow_d;
          col_q    <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q <= shadow_d;
            key_q   <= key_inv_d;
            cnt_q   <= 4'd1;
            phase_q <= ROUND;
          end
        end
        ROUND: begin
          shadow_q <= shadow_d;
          col_q    <= col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_q <= shadow_d;
            if (cnt_q == 4'd10) begin
              data_out_q <= shadow_d;
              done_q     <= 1'b1;
              cnt_q      <= 4'd0;
              phase_q    <= DONE;
            end else begin
              key_q <= key_inv_d;
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        default: phase_q <= IDLE;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aes128_decrypt32.sv
// Directed bench for aes128_decrypt32: FIPS-197 vectors, pause/hold/abort behaviour, and a
// scoreboard that checks every completed result and its active-edge latency.
module tb_aes128_decrypt32;

  logic         clock, reset, ce, done;
  logic [127:0] data_in, key, data_out;

  aes128_decrypt32 dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .data_in (data_in),
    .key     (key),
    .data_out(data_out),
    .done    (done)
  );

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  // clock/reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard state
  logic [127:0] exp_q[$];
  int           lat_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check_vec(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: counts active edges and pops/compares on every rising done.
  task automatic monitor();
    int           act_edges = 0;
    logic         prev_done = 1'b0;
    logic [127:0] e;
    int           el;
    forever begin
      @(posedge clock);
      #1;
      if (reset) act_edges = 0;
      else if (ce && !prev_done) act_edges++;
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: data_out %h with no pending result", data_out);
        end else begin
          e  = exp_q.pop_front();
          el = lat_q.pop_front();
          check_vec("plaintext", data_out, e);
          check_int("latency_edges", act_edges, el);
        end
        act_edges = 0;
      end
      prev_done = done;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_op(input logic [127:0] k, input logic [127:0] ct,
                          input logic [127:0] pt, input bit expect_result);
    if (expect_result) begin
      exp_q.push_back(pt);
      lat_q.push_back(55);
    end
    key     = k;
    data_in = ct;
    ce      = 1'b1;
  endtask

  task automatic wait_done(input string name, output int cycles);
    cycles = 0;
    while (!done && cycles < 300) begin
      tick();
      cycles++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, expected 1", name, done, cycles);
    end
  endtask

  task automatic release_ce(input logic [127:0] held);
    ce = 1'b0;
    tick();
    check_int("release_done", int'(done), 0);
    check_vec("release_data_out", data_out, held);
  endtask

  initial begin
    int cyc, act, paused_at;
    reset   = 1'b1;
    ce      = 1'b0;
    data_in = '0;
    key     = '0;
    fork
      monitor();
    join_none
    repeat (2) tick();
    reset = 1'b0;
    check_vec("reset_data_out", data_out, '0);
    check_int("reset_done", int'(done), 0);

    // App. C.1, then hold with ce high, then drop ce
    start_op(K_C1, C_C1, P_C1, 1'b1);
    wait_done("c1", cyc);
    check_int("c1_cycles", cyc, 55);
    repeat (3) begin
      tick();
      check_int("hold_done", int'(done), 1);
      check_vec("hold_data_out", data_out, P_C1);
    end
    release_ce(P_C1);

    // all-zero key and plaintext
    start_op('0, C_Z, '0, 1'b1);
    wait_done("zero", cyc);
    release_ce('0);

    // App. B
    start_op(K_B, C_B, P_B, 1'b1);
    wait_done("b", cyc);
    check_int("b_cycles", cyc, 55);
    release_ce(P_B);

    // App. C.1 with 3-cycle pauses before active edges 5, 14, 40 and inputs scrambled after load
    start_op(K_C1, C_C1, P_C1, 1'b1);
    cyc       = 0;
    act       = 0;
    paused_at = -1;
    while (!done && cyc < 300) begin
      if ((act == 4 || act == 13 || act == 39) && paused_at != act) begin
        ce = 1'b0;
        repeat (3) tick();
        cyc += 3;
        paused_at = act;
        ce = 1'b1;
      end
      tick();
      cyc++;
      act++;
      if (act == 1) begin
        data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        key     = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    check_int("pause_done", int'(done), 1);
    check_int("pause_cycles", cyc, 64);
    release_ce(P_C1);

    // reset at active edge 30 aborts with no result
    start_op(K_B, C_B, P_B, 1'b0);
    repeat (29) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ce    = 1'b0;
    check_int("abort_done", int'(done), 0);
    check_vec("abort_data_out", data_out, '0);
    tick();

    start_op(K_B, C_B, P_B, 1'b1);
    wait_done("b_after_abort", cyc);
    check_int("b_after_abort_cycles", cyc, 55);
    release_ce(P_B);

    tick();
    check_int("pending_results", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes128_decrypt32.md
Name: aes128_decrypt32

Overview:
- Iterative AES-128 decryption core (FIPS-197 inverse cipher) with a 32-bit column datapath: one state column per cycle, 4 cycles per round.
- Inverse counterpart of the team's 32-bit AES-128 encryption core, with the same ce/done handshake. It can be dropped in beside the encryptor for loopback and decrypt paths.
- Takes the cipher key, not the last round key. It expands the key forward internally, then unrolls the key schedule backwards on the fly.

Parameters:
- None. AES-128 only; Nr fixed at 10.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ce  input  1  run/hold enable; held high for the whole operation
- data_in  input  128  ciphertext; bits [127:120] are byte 0 (row 0, col 0); column c = bits [127-32c -: 32]
- key  input  128  cipher key, same byte order
- data_out  output  128  plaintext, registered; valid while done=1
- done  output  1  registered; high when data_out holds the result

Behaviour:
- Reset: done=0, data_out=0, phase=IDLE, all counters 0, state, shadow and key registers 0. Reset mid-operation aborts immediately; no partial result appears on data_out.
- Active edge: rising edge with ce=1 and done=0. With ce=0 and done=0, every register holds (pause). Resuming continues exactly where the core paused.
- Phases, counted in active edges:
  - LOAD (edge 1): capture data_in into the state register and key into the key register.
  - KEXP (edges 2-11): one forward round-key step per edge (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36). After edge 11 the key register holds K10.
  - ARK0 (edges 12-15): column c of the shadow register = state col c XOR K10 col c. At edge 15, shadow is copied to state.
  - ROUND r = 1..10 (4 edges each, edges 16-55): at step c (0..3):
    - t = InvSubBytes(InvShiftRows(state) col c) XOR K(10-r) col c.
    - shadow col c = InvMixColumns(t) for r ≤ 9; shadow col c = t for r = 10.
- Key unrolling: at step 3 of ARK0 and of rounds 1..9, the key register is updated from K(n) to K(n-1) by the inverse schedule:
  - w[i] = w[i+4] XOR w[i+3] for words 3, 2, 1.
  - word 0 = w[4] XOR SubWord(RotWord(w'[3])) XOR Rcon(n).
  - The round-key register is therefore K(10-r) throughout round r.
- State swap: at step 3 of each round, shadow (including the column just written) is copied to state.
- Completion: at edge 55, data_out is loaded with the final shadow (including col 3) and done is set to 1.
  - Latency is 55 active edges from the first ce-high edge.
  - done is visible after the 55th edge.
  - data_in and key are sampled only at LOAD; later changes are ignored.
- After done=1:
  - While ce=1, everything holds (done=1, data_out stable).
  - The first edge with ce=0 clears done to 0 and returns to IDLE. data_out keeps its value until the next completion.
  - A new operation starts on the next ce=1 edge.
- S-boxes: inverse S-box for the datapath (4 instances) and forward S-box for the key schedule (4 instances, shared between KEXP and unrolling). All combinational.

Test Plan:
- FIPS-197 App. C.1: key=000102030405060708090a0b0c0d0e0f, data_in=69c4e0d86a7b0430d8cdb78070b4c55a, ce held high -> done rises after exactly 55 edges; data_out=00112233445566778899aabbccddeeff.
- FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, data_in=3925841d02dc09fbdc118597196a0b32 -> data_out=3243f6a8885a308d313198a2e0370734.
- All-zero key, data_in=66e94bd4ef8a2c3b884cfa59ca342b2e -> data_out=0. Then drop ce for one edge -> done=0 and data_out unchanged. Raise ce with the App. B vector -> correct result after 55 further edges.
- Pause robustness: App. C.1 vector with ce deasserted for 3 cycles at edges 5, 14 and 40 -> same result; done rises after 55 active edges (64 total cycles). Changing data_in/key after edge 1 has no effect.
- Reset mid-operation at edge 30 -> done=0, data_out=0 the next cycle. A subsequent App. B run completes correctly in 55 edges.
- Round-trip: 1000 random key/plaintext pairs through the team's encryptor, ciphertext into this block -> data_out equals the original plaintext for every pair.
